// File: rtl/mac_tx.sv
`default_nettype none
// ============================================================================
// Module   : mac_tx
// Brief    : Ethernet MAC transmit path. Buffers whole frames of 32-bit words
//            in a word FIFO, then sends preamble, SFD, payload, optional pad
//            and CRC-32 FCS byte-wise to a GMII-style PHY. Defers on carrier
//            sense; on collision sends a jam pattern and drops the frame.
// Option   : MAC_TX_PAD_EN - pad payloads shorter than 60 bytes with 0x00.
// Revision : 1.0 - initial release
// ============================================================================
module mac_tx #(
  parameter int FIFO_ADDR_W  = 9,
  parameter int PREAMBLE_LEN = 7,
  parameter int IFG_LEN      = 12,
  parameter int JAM_LEN      = 4
) (
  input  logic        tx_clock,
  input  logic        reset,
  input  logic [31:0] data_in,
  input  logic        data_in_enable,
  input  logic        data_in_start,
  input  logic        data_in_end,
  input  logic        carrier_sense,
  input  logic        collision,
  output logic        tx_enable,
  output logic [7:0]  tx_data
);

  // Pointers carry one extra bit so a full FIFO is distinguishable from empty.
  localparam int            c_pw       = FIFO_ADDR_W + 1;
  localparam logic [c_pw-1:0] c_depth  = c_pw'(2 ** FIFO_ADDR_W);
  localparam logic [15:0]   c_pre_last = 16'(PREAMBLE_LEN - 1);
  localparam logic [15:0]   c_ifg_last = 16'(IFG_LEN - 1);
  localparam logic [15:0]   c_jam_last = 16'(JAM_LEN - 1);
  localparam logic [15:0]   c_fcs_last = 16'd3;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_DEFER,
    ST_PREAMBLE,
    ST_SFD,
    ST_DATA,
`ifdef MAC_TX_PAD_EN
    ST_PAD,
`endif
    ST_FCS,
    ST_JAM,
    ST_DISCARD,
    ST_IFG
  } state_t;

  // --------------------------------------------------------------------------
  // Word FIFO (bit 32 = end-of-frame flag) and write-side frame tracking
  // --------------------------------------------------------------------------
  logic [32:0]     mem [2**FIFO_ADDR_W];
  logic [c_pw-1:0] wr_ptr_q;
  logic [c_pw-1:0] base_q;
  logic [c_pw-1:0] rd_ptr_q;
  logic [c_pw-1:0] rd_ptr_d;
  logic            open_q;
  logic [c_pw-1:0] fcnt_q;

  logic            w_accept;
  logic            w_full;
  logic            w_wr_en;
  logic [c_pw-1:0] w_waddr;
  logic            w_inc;
  logic            w_dec;

  // Decide where an incoming word lands; a restart rewinds to the open frame base.
  always_comb begin
    w_accept = data_in_enable && (data_in_start || open_q);
    w_waddr  = (data_in_start && open_q) ? base_q : wr_ptr_q;
    w_full   = (w_waddr - rd_ptr_q) == c_depth;
    w_wr_en  = w_accept && !w_full;
    w_inc    = w_wr_en && data_in_end;
  end

  // Write pointer, frame base and open-frame flag.
  always_ff @(posedge tx_clock or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      base_q   <= '0;
      open_q   <= 1'b0;
    end else if (w_accept) begin
      if (w_full) begin
        // Overflow drops the whole frame under construction.
        wr_ptr_q <= open_q ? base_q : wr_ptr_q;
        open_q   <= 1'b0;
      end else begin
        wr_ptr_q <= w_waddr + c_pw'(1);
        if (data_in_start) base_q <= w_waddr;
        open_q   <= !data_in_end;
      end
    end
  end

  // FIFO storage; no reset so it maps onto plain RAM.
  always_ff @(posedge tx_clock) begin
    if (w_wr_en) mem[w_waddr[FIFO_ADDR_W-1:0]] <= {data_in_end, data_in};
  end

  // Count of complete frames waiting in the FIFO.
  always_ff @(posedge tx_clock or posedge reset) begin
    if (reset) fcnt_q <= '0;
    else       fcnt_q <= fcnt_q + c_pw'(w_inc) - c_pw'(w_dec);
  end

  // --------------------------------------------------------------------------
  // Transmit state machine
  // --------------------------------------------------------------------------
  state_t      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [1:0]  bidx_q, bidx_d;
  logic [31:0] crc_q, crc_d;
  logic        done_q, done_d;
  logic        tx_enable_d;
  logic [7:0]  tx_data_d;
  logic [32:0] w_head;
  logic [7:0]  w_byte;
  logic        w_txing;

`ifdef MAC_TX_PAD_EN
  logic [6:0] len_q;

  // Payload bytes sent so far (saturating), used to decide on padding.
  always_ff @(posedge tx_clock or posedge reset) begin
    if (reset) begin
      len_q <= '0;
    end else if (state_q == ST_SFD) begin
      len_q <= '0;
    end else if ((state_q == ST_DATA || state_q == ST_PAD) && len_q != 7'h7f) begin
      len_q <= len_q + 7'd1;
    end
  end
`endif

  // Reflected CRC-32 update, one byte taken LSB first.
  function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] b);
    logic [31:0] r;
    r = c;
    for (int i = 0; i < 8; i++) begin
      r = (r[0] ^ b[i]) ? ((r >> 1) ^ 32'hEDB8_8320) : (r >> 1);
    end
    return r;
  endfunction

  // Next state, FIFO read pointer, CRC and next pin values.
  always_comb begin
    state_d     = state_q;
    rd_ptr_d    = rd_ptr_q;
    bidx_d      = bidx_q;
    crc_d       = crc_q;
    done_d      = done_q;
    tx_enable_d = 1'b0;
    tx_data_d   = 8'h00;
    w_head      = mem[rd_ptr_q[FIFO_ADDR_W-1:0]];
    w_byte      = w_head[8*(3 - bidx_q) +: 8];

    w_txing = (state_q == ST_PREAMBLE) || (state_q == ST_SFD) ||
              (state_q == ST_DATA) || (state_q == ST_FCS);
`ifdef MAC_TX_PAD_EN
    if (state_q == ST_PAD) w_txing = 1'b1;
`endif

    case (state_q)
      ST_IDLE: begin
        if (fcnt_q != '0) state_d = ST_DEFER;
      end
      ST_DEFER: begin
        bidx_d = 2'd0;
        done_d = 1'b0;
        if (!carrier_sense) state_d = ST_PREAMBLE;
      end
      ST_PREAMBLE: begin
        tx_enable_d = 1'b1;
        tx_data_d   = 8'h55;
        if (cnt_q == c_pre_last) state_d = ST_SFD;
      end
      ST_SFD: begin
        tx_enable_d = 1'b1;
        tx_data_d   = 8'hD5;
        crc_d       = 32'hFFFF_FFFF;
        bidx_d      = 2'd0;
        state_d     = ST_DATA;
      end
      ST_DATA: begin
        tx_enable_d = 1'b1;
        tx_data_d   = w_byte;
        crc_d       = crc_byte(crc_q, w_byte);
        bidx_d      = bidx_q + 2'd1;
        if (bidx_q == 2'd3) begin
          rd_ptr_d = rd_ptr_q + c_pw'(1);
          if (w_head[32]) begin
            done_d  = 1'b1;
`ifdef MAC_TX_PAD_EN
            state_d = (len_q < 7'd59) ? ST_PAD : ST_FCS;
`else
            state_d = ST_FCS;
`endif
          end
        end
      end
`ifdef MAC_TX_PAD_EN
      ST_PAD: begin
        tx_enable_d = 1'b1;
        tx_data_d   = 8'h00;
        crc_d       = crc_byte(crc_q, 8'h00);
        if (len_q == 7'd59) state_d = ST_FCS;
      end
`endif
      ST_FCS: begin
        tx_enable_d = 1'b1;
        tx_data_d   = ~crc_q[7:0];
        crc_d       = {8'hFF, crc_q[31:8]};
        if (cnt_q == c_fcs_last) state_d = ST_IFG;
      end
      ST_JAM: begin
        tx_enable_d = 1'b1;
        tx_data_d   = 8'h55;
        if (cnt_q == c_jam_last) state_d = done_q ? ST_IFG : ST_DISCARD;
      end
      ST_DISCARD: begin
        // Drop the unsent remainder of the collided frame, one word per cycle.
        rd_ptr_d = rd_ptr_q + c_pw'(1);
        if (w_head[32]) state_d = ST_IFG;
      end
      ST_IFG: begin
        if (cnt_q == c_ifg_last) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    if (collision && w_txing) state_d = ST_JAM;

    w_dec = (state_d == ST_IFG) && (state_q != ST_IFG);
    cnt_d = (state_d != state_q) ? 16'd0 : cnt_q + 16'd1;
  end

  // State, sequencing registers and registered pins.
  always_ff @(posedge tx_clock or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      bidx_q    <= '0;
      crc_q     <= 32'hFFFF_FFFF;
      done_q    <= 1'b0;
      rd_ptr_q  <= '0;
      tx_enable <= 1'b0;
      tx_data   <= 8'h00;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bidx_q    <= bidx_d;
      crc_q     <= crc_d;
      done_q    <= done_d;
      rd_ptr_q  <= rd_ptr_d;
      tx_enable <= tx_enable_d;
      tx_data   <= tx_data_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mac_tx.sv
`default_nettype none
// ============================================================================
// Module   : tb_mac_tx
// Brief    : Self-checking bench for mac_tx. Expected PHY bytes are pushed to
//            a scoreboard queue when frames are written and compared as the
//            DUT drives them. Honours MAC_TX_PAD_EN in the reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mac_tx;

  localparam int IFG_LEN = 12;

  logic        tx_clock = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] data_in = '0;
  logic        data_in_enable = 1'b0;
  logic        data_in_start = 1'b0;
  logic        data_in_end = 1'b0;
  logic        carrier_sense = 1'b0;
  logic        collision = 1'b0;
  logic        tx_enable;
  logic [7:0]  tx_data;

  always #5 tx_clock = ~tx_clock;

  mac_tx dut (
    .tx_clock       (tx_clock),
    .reset          (reset),
    .data_in        (data_in),
    .data_in_enable (data_in_enable),
    .data_in_start  (data_in_start),
    .data_in_end    (data_in_end),
    .carrier_sense  (carrier_sense),
    .collision      (collision),
    .tx_enable      (tx_enable),
    .tx_data        (tx_data)
  );

  int         checks = 0;
  int         failures = 0;
  logic [7:0] sb[$];
  int         bursts[$];
  int         gaps[$];
  int         run = 0;
  int         idle_run = 0;
  logic       prev_en = 1'b0;
  logic [31:0] fw[64];
  int         fn = 0;
  logic [7:0] fb[$];

  // Scoreboard monitor: every enabled byte is popped and compared; idle bytes must be 0.
  always @(negedge tx_clock) begin
    logic [7:0] exp_b;
    if (tx_enable === 1'b1) begin
      if (!prev_en) begin
        gaps.push_back(idle_run);
        run = 0;
      end
      run++;
      checks++;
      if (sb.size() == 0) begin
        failures++;
        $display("FAIL unexpected_byte got=%02h required=none", tx_data);
      end else begin
        exp_b = sb.pop_front();
        if (tx_data !== exp_b) begin
          failures++;
          $display("FAIL tx_byte got=%02h required=%02h", tx_data, exp_b);
        end
      end
    end else begin
      if (prev_en) bursts.push_back(run);
      idle_run = prev_en ? 1 : idle_run + 1;
      checks++;
      if (tx_data !== 8'h00) begin
        failures++;
        $display("FAIL idle_data got=%02h required=00", tx_data);
      end
    end
    prev_en = (tx_enable === 1'b1);
  end

  // Reference model: full byte stream of the frame in fw[0..fn-1].
  task automatic build_expected();
    logic [31:0] crc;
    logic [7:0]  pay[$];
    fb.delete();
    for (int i = 0; i < fn; i++)
      for (int k = 3; k >= 0; k--) pay.push_back(fw[i][8*k +: 8]);
`ifdef MAC_TX_PAD_EN
    while (pay.size() < 60) pay.push_back(8'h00);
`endif
    crc = 32'hFFFF_FFFF;
    foreach (pay[j]) begin
      crc = crc ^ {24'h0, pay[j]};
      for (int s = 0; s < 8; s++) crc = crc[0] ? ((crc >> 1) ^ 32'hEDB8_8320) : (crc >> 1);
    end
    crc = ~crc;
    for (int j = 0; j < 7; j++) fb.push_back(8'h55);
    fb.push_back(8'hD5);
    foreach (pay[j]) fb.push_back(pay[j]);
    for (int j = 0; j < 4; j++) fb.push_back(crc[8*j +: 8]);
  endtask

  // keep < 0: whole frame expected; otherwise first 'keep' bytes then a 4-byte jam.
  task automatic push_expected(input int keep, output int burst_len);
    build_expected();
    if (keep < 0) begin
      foreach (fb[j]) sb.push_back(fb[j]);
      burst_len = fb.size();
    end else begin
      for (int j = 0; j < keep; j++) sb.push_back(fb[j]);
      for (int j = 0; j < 4; j++) sb.push_back(8'h55);
      burst_len = keep + 4;
    end
  endtask

  task automatic fill_random(input int n);
    fn = n;
    for (int i = 0; i < n; i++) fw[i] = $urandom;
  endtask

  task automatic send_frame();
    for (int i = 0; i < fn; i++) begin
      data_in        = fw[i];
      data_in_enable = 1'b1;
      data_in_start  = (i == 0);
      data_in_end    = (i == fn - 1);
      @(negedge tx_clock);
    end
    data_in_enable = 1'b0;
    data_in_start  = 1'b0;
    data_in_end    = 1'b0;
  endtask

  task automatic wait_drain(input int budget);
    int quiet = 0;
    bit ok = 1'b0;
    for (int c = 0; c < budget; c++) begin
      @(negedge tx_clock); #1;
      if (sb.size() == 0 && tx_enable !== 1'b1) quiet++;
      else quiet = 0;
      if (quiet >= 20) begin
        ok = 1'b1;
        break;
      end
    end
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL drain_timeout got pending=%0d required pending=0", sb.size());
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge tx_clock);
    checks++;
    if (tx_enable !== 1'b0 || tx_data !== 8'h00) begin
      failures++;
      $display("FAIL reset_outputs got en=%b data=%02h required en=0 data=00", tx_enable, tx_data);
    end
    reset = 1'b0;
    bursts.delete();
    gaps.delete();
    repeat (40) @(negedge tx_clock);
    #1;
    checks++;
    if (gaps.size() != 0) begin
      failures++;
      $display("FAIL reset_idle got bursts=%0d required 0", gaps.size());
    end
  endtask

  task automatic test_basic();
    int lenb;
    bursts.delete();
    gaps.delete();
    fill_random(15);
    fw[0] = 32'hFFFF_FFFF;
    push_expected(-1, lenb);
    send_frame();
    wait_drain(400);
    checks++;
    if (bursts.size() != 1 || bursts[0] != 72) begin
      failures++;
      $display("FAIL basic_len got=%0d required=72", (bursts.size() > 0) ? bursts[0] : -1);
    end
  endtask

  task automatic test_defer();
    int lenb;
    bursts.delete();
    gaps.delete();
    carrier_sense = 1'b1;
    fill_random(2);
    push_expected(-1, lenb);
    send_frame();
    repeat (40) @(negedge tx_clock);
    #1;
    checks++;
    if (gaps.size() != 0) begin
      failures++;
      $display("FAIL defer_hold got bursts=%0d required 0", gaps.size());
    end
    carrier_sense = 1'b0;
    @(negedge tx_clock); #1;
    checks++;
    if (tx_enable !== 1'b0) begin
      failures++;
      $display("FAIL defer_release_early got en=%b required 0", tx_enable);
    end
    @(negedge tx_clock); #1;
    checks++;
    if (tx_enable !== 1'b1 || tx_data !== 8'h55) begin
      failures++;
      $display("FAIL defer_release got en=%b data=%02h required en=1 data=55", tx_enable, tx_data);
    end
    wait_drain(300);
    checks++;
    if (bursts.size() != 1 || bursts[0] != lenb) begin
      failures++;
      $display("FAIL defer_len got=%0d required=%0d", (bursts.size() > 0) ? bursts[0] : -1, lenb);
    end
  endtask

  task automatic test_collision();
    int len_a;
    int len_b;
    bit found = 1'b0;
    bursts.delete();
    gaps.delete();
    // Collision seen while the 5th data byte is on the pins: the byte already
    // registered behind it (6th) still goes out, then the jam.
    fill_random(8);
    push_expected(8 + 6, len_a);
    send_frame();
    fill_random(3);
    push_expected(-1, len_b);
    send_frame();
    for (int c = 0; c < 200; c++) begin
      @(negedge tx_clock); #1;
      if (tx_enable === 1'b1 && run == 13) begin
        found = 1'b1;
        break;
      end
    end
    checks++;
    if (!found) begin
      failures++;
      $display("FAIL collision_window got=not_reached required=13th_byte");
    end
    collision = 1'b1;
    @(negedge tx_clock);
    collision = 1'b0;
    wait_drain(600);
    checks++;
    if (bursts.size() != 2 || bursts[0] != len_a || bursts[1] != len_b) begin
      failures++;
      $display("FAIL collision_bursts got n=%0d a=%0d required n=2 a=%0d b=%0d",
               bursts.size(), (bursts.size() > 0) ? bursts[0] : -1, len_a, len_b);
    end
    checks++;
    if (gaps.size() != 2 || gaps[1] < IFG_LEN) begin
      failures++;
      $display("FAIL collision_ifg got=%0d required>=%0d", (gaps.size() > 1) ? gaps[1] : -1, IFG_LEN);
    end
  endtask

  task automatic test_pad();
    int lenb;
    bursts.delete();
    gaps.delete();
    fn = 1;
    fw[0] = 32'hDEAD_BEEF;
    push_expected(-1, lenb);
    send_frame();
    wait_drain(300);
    checks++;
    if (bursts.size() != 1 || bursts[0] != lenb) begin
      failures++;
      $display("FAIL pad_len got=%0d required=%0d", (bursts.size() > 0) ? bursts[0] : -1, lenb);
    end
  endtask

  task automatic test_restart();
    int lenb;
    bursts.delete();
    gaps.delete();
    // Orphan words with no open frame.
    for (int i = 0; i < 3; i++) begin
      data_in = 32'h1111_0000 + i;
      data_in_enable = 1'b1;
      @(negedge tx_clock);
    end
    // Partial frame that gets restarted.
    data_in = 32'hAAAA_0000; data_in_start = 1'b1;
    @(negedge tx_clock);
    data_in = 32'hAAAA_0001; data_in_start = 1'b0;
    @(negedge tx_clock);
    data_in_enable = 1'b0;
    fill_random(3);
    push_expected(-1, lenb);
    send_frame();
    wait_drain(300);
    checks++;
    if (bursts.size() != 1 || bursts[0] != lenb) begin
      failures++;
      $display("FAIL restart_frames got n=%0d required n=1 len=%0d", bursts.size(), lenb);
    end
  endtask

  task automatic test_back_to_back();
    int len_a;
    int len_b;
    bursts.delete();
    gaps.delete();
    fill_random(2);
    push_expected(-1, len_a);
    send_frame();
    fill_random(3);
    push_expected(-1, len_b);
    send_frame();
    wait_drain(400);
    // IFG_LEN idle cycles plus one cycle each in IDLE and DEFER.
    checks++;
    if (gaps.size() != 2 || gaps[1] != IFG_LEN + 2) begin
      failures++;
      $display("FAIL b2b_gap got=%0d required=%0d", (gaps.size() > 1) ? gaps[1] : -1, IFG_LEN + 2);
    end
    checks++;
    if (bursts.size() != 2 || bursts[1] != len_b) begin
      failures++;
      $display("FAIL b2b_len got n=%0d required n=2 len=%0d", bursts.size(), len_b);
    end
  endtask

  task automatic test_reset_midframe();
    int lenb;
    bit found = 1'b0;
    fill_random(20);
    push_expected(-1, lenb);
    send_frame();
    for (int c = 0; c < 200; c++) begin
      @(negedge tx_clock); #1;
      if (tx_enable === 1'b1 && run == 20) begin
        found = 1'b1;
        break;
      end
    end
    checks++;
    if (!found) begin
      failures++;
      $display("FAIL midframe_window got=not_reached required=20th_byte");
    end
    #1 reset = 1'b1;
    #1;
    checks++;
    if (tx_enable !== 1'b0 || tx_data !== 8'h00) begin
      failures++;
      $display("FAIL midframe_reset got en=%b data=%02h required en=0 data=00", tx_enable, tx_data);
    end
    sb.delete();
    repeat (2) @(negedge tx_clock);
    reset = 1'b0;
    bursts.delete();
    gaps.delete();
    repeat (40) @(negedge tx_clock);
    #1;
    checks++;
    if (gaps.size() != 0) begin
      failures++;
      $display("FAIL midframe_flush got bursts=%0d required 0", gaps.size());
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_defer();
    test_collision();
    test_pad();
    test_restart();
    test_back_to_back();
    test_reset_midframe();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
